// File: rtl/pq_candidate_sieve.sv
// pq_candidate_sieve
//
// Pre-filter between the random number generator and the pq FIFO that feeds
// the Miller-Rabin tester. Each accepted word becomes an odd, full-width
// candidate (MSB and LSB forced to 1). A bit-serial engine then computes its
// residues modulo the ten odd primes 3..31, one candidate bit per cycle, MSB
// first. Candidates with no small factor are written to the FIFO. The rest
// are discarded.
//
// Optional feature: define SIEVE_STATS_EN to build the saturating
// pass/reject statistics counters. When it is undefined, there are no counter
// registers and both count outputs are tied to 0.

module pq_candidate_sieve #(
  parameter int NUM_BITS = 128,
  parameter int CNT_BITS = 16
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                rng_valid,
  input  logic [NUM_BITS-1:0] rng_data,
  output logic                rng_ready,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [NUM_BITS-1:0] fifo_dout,
  output logic [CNT_BITS-1:0] pass_count,
  output logic [CNT_BITS-1:0] reject_count
);

  localparam int NUM_PRIMES = 10;
  localparam int IDX_W      = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SIEVE = 2'd1,
    CHECK = 2'd2,
    WRITE = 2'd3
  } state_t;

  // The sieve primes, indexed 0..9.
  function automatic logic [5:0] prime_at(input int i);
    case (i)
      0:       prime_at = 6'd3;
      1:       prime_at = 6'd5;
      2:       prime_at = 6'd7;
      3:       prime_at = 6'd11;
      4:       prime_at = 6'd13;
      5:       prime_at = 6'd17;
      6:       prime_at = 6'd19;
      7:       prime_at = 6'd23;
      8:       prime_at = 6'd29;
      default: prime_at = 6'd31;
    endcase
  endfunction

  // One remainder step: r' = (2r + b) mod p. Since r < p, t < 2p <= 62, so
  // a single conditional subtract is enough.
  function automatic logic [4:0] rem_step(input logic [4:0] r, input logic b,
                                          input logic [5:0] p);
    logic [5:0] t;
    t = {r, b};
    if (t >= p) rem_step = 5'(t - p);
    else        rem_step = 5'(t);
  endfunction

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] cand_q, cand_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [4:0]          rem_q [NUM_PRIMES];
  logic [4:0]          rem_d [NUM_PRIMES];
  logic                fifo_wr_en_q, fifo_wr_en_d;
  logic                any_zero;

  // Detect a small factor: any residue equal to zero.
  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < NUM_PRIMES; i++) begin
      if (rem_q[i] == 5'd0) any_zero = 1'b1;
    end
  end

  // Next-state logic for the FSM, the candidate, the bit index and the residues.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d      = state_q;
    cand_d       = cand_q;
    bit_idx_d    = bit_idx_q;
    rem_d        = rem_q;
    fifo_wr_en_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rng_valid) begin
          cand_d    = rng_data | {1'b1, {(NUM_BITS-1){1'b0}}} | NUM_BITS'(1);
          bit_idx_d = IDX_W'(NUM_BITS - 1);
          for (int i = 0; i < NUM_PRIMES; i++) rem_d[i] = 5'd0;
          state_d   = SIEVE;
        end
      end
      SIEVE: begin
        for (int i = 0; i < NUM_PRIMES; i++) begin
          rem_d[i] = rem_step(rem_q[i], cand_q[bit_idx_q], prime_at(i));
        end
        bit_idx_d = bit_idx_q - IDX_W'(1);
        if (bit_idx_q == '0) state_d = CHECK;
      end
      CHECK: begin
        state_d = any_zero ? IDLE : WRITE;
      end
      WRITE: begin
        if (!fifo_full) begin
          fifo_wr_en_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Every register clears asynchronously.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      bit_idx_q    <= '0;
      fifo_wr_en_q <= 1'b0;
      // NOTE: the residue bank is only ten small registers, so it is reset
      // like any other flop rather than being treated as an unreset memory.
      for (int i = 0; i < NUM_PRIMES; i++) rem_q[i] <= 5'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples its pre-edge _d value regardless of statement order.
      state_q      <= state_d;
      cand_q       <= cand_d;
      bit_idx_q    <= bit_idx_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      rem_q        <= rem_d;
    end
  end

  assign rng_ready  = (state_q == IDLE);
  assign fifo_wr_en = fifo_wr_en_q;
  assign fifo_dout  = cand_q;

`ifdef SIEVE_STATS_EN
  logic [CNT_BITS-1:0] pass_count_q, pass_count_d;
  logic [CNT_BITS-1:0] reject_count_q, reject_count_d;

  // Saturating statistics: a pass is a FIFO write, a reject is a CHECK hit.
  always_comb begin
    pass_count_d   = pass_count_q;
    reject_count_d = reject_count_q;
    if (state_q == WRITE && !fifo_full && pass_count_q != '1)
      pass_count_d = pass_count_q + CNT_BITS'(1);
    if (state_q == CHECK && any_zero && reject_count_q != '1)
      reject_count_d = reject_count_q + CNT_BITS'(1);
  end

  // Counter registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pass_count_q   <= '0;
      reject_count_q <= '0;
    end else begin
      pass_count_q   <= pass_count_d;
      reject_count_q <= reject_count_d;
    end
  end

  assign pass_count   = pass_count_q;
  assign reject_count = reject_count_q;
`else
  assign pass_count   = '0;
  assign reject_count = '0;
`endif

endmodule

// File: tb/tb_pq_candidate_sieve.sv
// Testbench for pq_candidate_sieve with NUM_BITS=16 and CNT_BITS=4.
// Expected counter values follow SIEVE_STATS_EN: they are the modelled counts
// when the macro is defined and 0 when it is not.

module tb_pq_candidate_sieve;

  localparam int NB = 16;
  localparam int CB = 4;
`ifdef SIEVE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          areset;
  logic          rng_valid;
  logic [NB-1:0] rng_data;
  logic          rng_ready;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [NB-1:0] fifo_dout;
  logic [CB-1:0] pass_count;
  logic [CB-1:0] reject_count;

  int checks = 0;
  int errors = 0;
  int exp_pass = 0;
  int exp_rej  = 0;

  pq_candidate_sieve #(.NUM_BITS(NB), .CNT_BITS(CB)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .rng_valid    (rng_valid),
    .rng_data     (rng_data),
    .rng_ready    (rng_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_dout    (fifo_dout),
    .pass_count   (pass_count),
    .reject_count (reject_count)
  );

  always #5 aclk = ~aclk;

  function automatic logic [CB-1:0] sat(input int n);
    if (!STATS)   return '0;
    if (n > 15)   return 4'd15;
    return CB'(n);
  endfunction

  // Present a word and return 1 time unit after the accept edge E0.
  task automatic accept(input logic [NB-1:0] d);
    @(negedge aclk);
    checks++;
    if (rng_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: rng_ready=%b required 1", rng_ready);
    end
    rng_valid = 1'b1;
    rng_data  = d;
    @(posedge aclk);
    #1;
    rng_valid = 1'b0;
  endtask

  // Advance n clock edges, ending 1 time unit after the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    areset = 1'b1; rng_valid = 1'b0; rng_data = '0; fifo_full = 1'b0;
    edges(2);
    checks++;
    if ({rng_ready, fifo_wr_en, fifo_dout, pass_count, reject_count} !==
        {1'b1, 1'b0, 16'h0000, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_values: ready=%b wr=%b dout=%h pass=%0d rej=%0d required 1 0 0000 0 0",
               rng_ready, fifo_wr_en, fifo_dout, pass_count, reject_count);
    end
    @(negedge aclk);
    areset = 1'b0;
  endtask

  // Reject a candidate: ready must come back after E17, and there is no write.
  task automatic test_reject(input logic [NB-1:0] d, input string name);
    bit wr_seen = 0;
    accept(d);
    for (int k = 1; k <= 16; k++) begin
      edges(1);
      if (fifo_wr_en) wr_seen = 1;
      if (k == 16) begin
        checks++;
        if (rng_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_busy_e16: rng_ready=%b required 0", name, rng_ready);
        end
      end
    end
    edges(1);  // E17: CHECK rejects
    exp_rej++;
    checks++;
    if (rng_ready !== 1'b1 || reject_count !== sat(exp_rej)) begin
      errors++;
      $display("FAIL %s_e17: ready=%b rej=%0d required 1 %0d", name, rng_ready,
               reject_count, sat(exp_rej));
    end
    edges(2);
    if (fifo_wr_en) wr_seen = 1;
    checks++;
    if (wr_seen !== 1'b0 || pass_count !== sat(exp_pass)) begin
      errors++;
      $display("FAIL %s_no_write: wr_seen=%b pass=%0d required 0 %0d", name, wr_seen,
               pass_count, sat(exp_pass));
    end
  endtask

  task automatic test_pass;
    accept(16'h0002);
    checks++;
    if (fifo_dout !== 16'h8003) begin
      errors++;
      $display("FAIL pass_cand: fifo_dout=%h required 8003", fifo_dout);
    end
    edges(17);  // after E17: in WRITE
    checks++;
    if (fifo_wr_en !== 1'b0 || rng_ready !== 1'b0) begin
      errors++;
      $display("FAIL pass_e17: wr=%b ready=%b required 0 0", fifo_wr_en, rng_ready);
    end
    edges(1);  // after E18
    exp_pass++;
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_dout !== 16'h8003 || rng_ready !== 1'b1 ||
        pass_count !== sat(exp_pass)) begin
      errors++;
      $display("FAIL pass_e18: wr=%b dout=%h ready=%b pass=%0d required 1 8003 1 %0d",
               fifo_wr_en, fifo_dout, rng_ready, pass_count, sat(exp_pass));
    end
    edges(1);
    checks++;
    if (fifo_wr_en !== 1'b0 || fifo_dout !== 16'h8003) begin
      errors++;
      $display("FAIL pass_e19: wr=%b dout=%h required 0 8003", fifo_wr_en, fifo_dout);
    end
  endtask

  task automatic test_backpressure;
    int bad = 0;
    accept(16'h0002);
    edges(16);  // after E16: in CHECK
    fifo_full = 1'b1;
    for (int k = 17; k <= 26; k++) begin
      edges(1);
      if (k >= 18 && (fifo_wr_en !== 1'b0 || rng_ready !== 1'b0 ||
                      fifo_dout !== 16'h8003)) bad++;
    end
    checks++;
    if (bad != 0 || pass_count !== sat(exp_pass)) begin
      errors++;
      $display("FAIL bp_hold: bad_cycles=%0d pass=%0d required 0 %0d", bad, pass_count,
               sat(exp_pass));
    end
    fifo_full = 1'b0;
    edges(1);  // E27: write
    exp_pass++;
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_dout !== 16'h8003 || pass_count !== sat(exp_pass)) begin
      errors++;
      $display("FAIL bp_release: wr=%b dout=%h pass=%0d required 1 8003 %0d", fifo_wr_en,
               fifo_dout, pass_count, sat(exp_pass));
    end
    edges(1);
    checks++;
    if (fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_single: wr=%b required 0", fifo_wr_en);
    end
  endtask

  task automatic test_reset_mid_sieve;
    bit wr_seen = 0;
    accept(16'h0002);
    edges(8);
    areset = 1'b1;
    #1;
    exp_pass = 0;
    exp_rej  = 0;
    checks++;
    if ({rng_ready, fifo_wr_en, fifo_dout, pass_count, reject_count} !==
        {1'b1, 1'b0, 16'h0000, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL midreset_async: ready=%b wr=%b dout=%h pass=%0d rej=%0d required 1 0 0000 0 0",
               rng_ready, fifo_wr_en, fifo_dout, pass_count, reject_count);
    end
    @(negedge aclk);
    areset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      edges(1);
      if (fifo_wr_en) wr_seen = 1;
    end
    checks++;
    if (wr_seen !== 1'b0 || rng_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_lost: wr_seen=%b ready=%b required 0 1", wr_seen, rng_ready);
    end
    test_pass();
  endtask

  task automatic test_saturation;
    for (int n = 0; n < 20; n++) test_reject(16'h0000, "sat");
    checks++;
    if (reject_count !== sat(exp_rej) || (STATS && reject_count !== 4'd15)) begin
      errors++;
      $display("FAIL saturation: rej=%0d required %0d", reject_count, sat(exp_rej));
    end
  endtask

  initial begin
    test_reset();
    test_reject(16'h0000, "rej3");
    test_pass();
    test_reject(16'h0AE4, "rej31");
    test_backpressure();
    test_reset_mid_sieve();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
